// File: rtl/psddivide_seq.sv
// Sequential unsigned 32-bit restoring divider: one quotient bit per clock, result held until the next completion.
// Optional macro PSDDIV_DIVZERO_FAST_EN: a zero divisor finishes after a single DIVIDE cycle.
module psddivide_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  output logic        busy,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] rest
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] DIVIDE = 1'b1;

  logic [0:0]  state;
  logic [31:0] q;
  logic [31:0] d;
  logic [31:0] r;
  logic [4:0]  cnt;
`ifdef PSDDIV_DIVZERO_FAST_EN
  logic        dz;
`endif

  logic [32:0] r_sh;
  logic [31:0] sub;
  logic        ge;
  logic [31:0] q_nx;
  logic [31:0] r_nx;
  logic        last;
  logic        start;

  // R is kept 32 bits wide: a restored remainder is always below D, so bit 32 is
  // only ever set transiently in the shifted value, which the 33-bit compare covers.
  always_comb begin
    r_sh  = {r, q[31]};
    ge    = (r_sh >= {1'b0, d});
    sub   = r_sh[31:0] - d;
    q_nx  = {q[30:0], ge};
    r_nx  = ge ? sub : r_sh[31:0];
`ifdef PSDDIV_DIVZERO_FAST_EN
    last  = (state == DIVIDE) && ((cnt == 5'd31) || dz);
`else
    last  = (state == DIVIDE) && (cnt == 5'd31);
`endif
    // Accepting run on the completion edge gives back-to-back operation
    start = run && ((state == IDLE) || last);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      q        <= '0;
      d        <= '0;
      r        <= '0;
      cnt      <= '0;
      quotient <= '0;
      rest     <= '0;
`ifdef PSDDIV_DIVZERO_FAST_EN
      dz       <= 1'b0;
`endif
    end else begin
      if (last) begin
`ifdef PSDDIV_DIVZERO_FAST_EN
        if (dz) begin
          quotient <= '1;
          rest     <= q;
        end else begin
          quotient <= q_nx;
          rest     <= r_nx;
        end
`else
        quotient <= q_nx;
        rest     <= r_nx;
`endif
      end

      if (start) begin
        state <= DIVIDE;
        busy  <= 1'b1;
        q     <= dividend;
        d     <= divisor;
        r     <= '0;
        cnt   <= '0;
`ifdef PSDDIV_DIVZERO_FAST_EN
        dz    <= (divisor == 32'd0);
`endif
      end else if (last) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (state == DIVIDE) begin
        q   <= q_nx;
        r   <= r_nx;
        cnt <= cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_psddivide_seq.sv
// Self-checking bench for psddivide_seq: directed cases plus randomized operands against a q=a/b, r=a%b model.
// Honours PSDDIV_DIVZERO_FAST_EN for the expected busy length of a zero-divisor operation.
module tb_psddivide_seq;

  logic        clock;
  logic        reset;
  logic        run;
  logic        busy;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] rest;

  int unsigned n_cmp;
  int unsigned n_err;

  psddivide_seq dut (
    .clock    (clock),
    .reset    (reset),
    .run      (run),
    .busy     (busy),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .rest     (rest)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
  endfunction

  function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ? a : a % b;
  endfunction

  function automatic int unsigned ref_busy(input logic [31:0] b);
`ifdef PSDDIV_DIVZERO_FAST_EN
    return (b == 32'd0) ? 1 : 32;
`else
    return 32;
`endif
  endfunction

  // Single operation: pulse run, scramble operands, count busy cycles, check result.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int unsigned n;
    @(negedge clock);
    dividend = a;
    divisor  = b;
    run      = 1'b1;
    @(negedge clock);
    run      = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clock);
    end
    check_eq({tag, "_busy"}, n, ref_busy(b));
    check_eq({tag, "_q"}, quotient, ref_q(a, b));
    check_eq({tag, "_r"}, rest, ref_r(a, b));
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    run      = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_q", quotient, 32'd0);
    check_eq("rst_r", rest, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    do_op("d100_7", 32'd100, 32'd7);
    do_op("div0", 32'd1234, 32'd0);

    // Back-to-back: FFFFFFFF/1 then 5/9 with run held high
    @(negedge clock);
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'd1;
    run      = 1'b1;
    @(negedge clock);
    dividend = 32'd5;
    divisor  = 32'd9;
    repeat (31) @(negedge clock);
    check_eq("b2b_hold_q", quotient, 32'hFFFF_FFFF);
    check_eq("b2b_hold_r", rest, 32'd1234);
    check_eq("b2b_busy31", {31'd0, busy}, 32'd1);
    @(negedge clock);
    run = 1'b0;
    check_eq("b2b_q1", quotient, 32'hFFFF_FFFF);
    check_eq("b2b_r1", rest, 32'd0);
    check_eq("b2b_busy32", {31'd0, busy}, 32'd1);
    repeat (16) @(negedge clock);
    check_eq("b2b_mid_q", quotient, 32'hFFFF_FFFF);
    repeat (16) @(negedge clock);
    check_eq("b2b_busy_end", {31'd0, busy}, 32'd0);
    check_eq("b2b_q2", quotient, 32'd0);
    check_eq("b2b_r2", rest, 32'd5);

    // run pulsed mid-operation with new operands is dropped
    @(negedge clock);
    dividend = 32'd1000;
    divisor  = 32'd10;
    run      = 1'b1;
    @(negedge clock);
    run = 1'b0;
    repeat (9) @(negedge clock);
    dividend = 32'd7;
    divisor  = 32'd7;
    run      = 1'b1;
    @(negedge clock);
    run = 1'b0;
    repeat (21) @(negedge clock);
    check_eq("ign_busy31", {31'd0, busy}, 32'd1);
    @(negedge clock);
    check_eq("ign_busy", {31'd0, busy}, 32'd0);
    check_eq("ign_q", quotient, 32'd100);
    check_eq("ign_r", rest, 32'd0);
    repeat (3) @(negedge clock);
    check_eq("ign_no_restart", {31'd0, busy}, 32'd0);
    check_eq("ign_q_held", quotient, 32'd100);

    // Asynchronous reset in the middle of 1000/3
    @(negedge clock);
    dividend = 32'd1000;
    divisor  = 32'd3;
    run      = 1'b1;
    @(negedge clock);
    run = 1'b0;
    repeat (14) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_q", quotient, 32'd0);
    check_eq("arst_r", rest, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check_eq("arst_idle_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_idle_q", quotient, 32'd0);
    do_op("post_rst", 32'd9, 32'd2);

    // Randomized operands, mixing narrow divisors, zero and full-range values
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 16);
        2:       b = $urandom >> $urandom_range(0, 31);
        3:       b = a + $urandom_range(0, 3);
        default: b = $urandom;
      endcase
      do_op("rand", a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
